// File: rtl/signed_div.sv
// signed_div: sequential signed divider, 2N-bit dividend / N-bit divisor.
// Restoring shift-subtract on magnitudes. One quotient bit is produced per
// clock. The signs are applied in a final FIX cycle.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - synchronous active-low reset
//   start     - request, sampled only in IDLE
//   dividend  - 2N-bit signed dividend, captured on the accepting edge
//   divisor   - N-bit signed divisor, captured on the accepting edge
//   quotient  - 2N-bit signed quotient (registered, truncated toward zero)
//   remainder - N-bit signed remainder (registered, takes the dividend's sign)
//   busy      - high while a division is in progress
//   done      - one-cycle pulse when the results become valid
//   dbz       - divide-by-zero flag for the last operation
//   ovf       - quotient overflow flag (-2^(2N-1) / -1)
module signed_div #(
    parameter int unsigned N = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*N-1:0]     dividend,
    input  logic [N-1:0]       divisor,
    output logic [2*N-1:0]     quotient,
    output logic [N-1:0]       remainder,
    output logic               busy,
    output logic               done,
    output logic               dbz,
    output logic               ovf
);

    localparam int unsigned W  = 2 * N;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    state_t          state_q;
    logic [W-1:0]    dvd_q;       // dividend magnitude, shifted out MSB first
    logic [N-1:0]    dvs_q;       // divisor magnitude
    logic [N-1:0]    part_q;      // partial remainder, always < dvs_q
    logic [W-1:0]    quo_q;       // quotient magnitude
    logic [CW-1:0]   cnt_q;
    logic            sgn_q_q;
    logic            sgn_r_q;
    logic            dz_q;
    logic [W-1:0]    quotient_q;
    logic [N-1:0]    remainder_q;
    logic            busy_q;
    logic            done_q;
    logic            dbz_q;
    logic            ovf_q;

    logic [W-1:0]    dvd_mag_c;
    logic [N-1:0]    dvs_mag_c;
    logic [N:0]      part_sh_c;
    logic            ge_c;
    logic [N-1:0]    part_d;
    logic [W-1:0]    quo_d;
    logic [W-1:0]    quo_fix_c;
    logic [N-1:0]    rem_fix_c;

    // Operand magnitudes. The unsigned reading of the negation is exact even
    // for the most negative value (e.g. -512 -> 512 in 10 unsigned bits).
    always_comb begin
        dvd_mag_c = dividend[W-1] ? (~dividend + W'(1)) : dividend;
        dvs_mag_c = divisor[N-1]  ? (~divisor  + N'(1)) : divisor;
    end

    // One restoring step, plus the sign fix-up of the final magnitudes.
    always_comb begin
        part_sh_c = {part_q, dvd_q[W-1]};
        ge_c      = (part_sh_c >= {1'b0, dvs_q});
        part_d    = ge_c ? N'(part_sh_c - {1'b0, dvs_q}) : N'(part_sh_c);
        quo_d     = {quo_q[W-2:0], ge_c};
        quo_fix_c = sgn_q_q ? (~quo_q + W'(1)) : quo_q;
        rem_fix_c = sgn_r_q ? (~part_q + N'(1)) : part_q;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            part_q      <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            sgn_q_q     <= 1'b0;
            sgn_r_q     <= 1'b0;
            dz_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            dz_q    <= 1'b1;
                            state_q <= FIX;
                        end else begin
                            dz_q    <= 1'b0;
                            dvd_q   <= dvd_mag_c;
                            dvs_q   <= dvs_mag_c;
                            sgn_q_q <= dividend[W-1] ^ divisor[N-1];
                            sgn_r_q <= dividend[W-1];
                            part_q  <= '0;
                            quo_q   <= '0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    part_q <= part_d;
                    quo_q  <= quo_d;
                    dvd_q  <= {dvd_q[W-2:0], 1'b0};
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (dz_q) begin
                        quotient_q  <= '0;
                        remainder_q <= '0;
                        dbz_q       <= 1'b1;
                        ovf_q       <= 1'b0;
                    end else begin
                        quotient_q  <= quo_fix_c;
                        remainder_q <= rem_fix_c;
                        dbz_q       <= 1'b0;
                        // A positive result with the MSB set can only be +2^(W-1).
                        ovf_q       <= ~sgn_q_q & quo_q[W-1];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_signed_div.sv
// tb_signed_div: directed self-checking bench for signed_div (N=5).
module tb_signed_div;

    localparam int unsigned N = 5;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           dbz;
    logic           ovf;

    int total  = 0;
    int passed = 0;

    signed_div #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Present operands for one accepting edge, scramble them afterwards,
    // then wait (bounded) for done and check latency and busy.
    task automatic run_op(input string tag, input logic [2*N-1:0] a, input logic [N-1:0] b,
                          input int exp_lat);
        int lat;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = (2*N)'($urandom);
        divisor  = N'($urandom);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if ((i == 1 || i == 10) && exp_lat > i) check({tag, "_busy"}, 32'(busy), 32'(1));
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_at_done"}, 32'(busy), 32'(0));
    endtask

    task automatic check_res(input string tag, input logic [2*N-1:0] eq, input logic [N-1:0] er,
                             input logic edbz, input logic eovf);
        check({tag, "_q"},   32'(quotient),  32'(eq));
        check({tag, "_r"},   32'(remainder), 32'(er));
        check({tag, "_dbz"}, 32'(dbz),       32'(edbz));
        check({tag, "_ovf"}, 32'(ovf),       32'(eovf));
    endtask

    initial begin
        int seen_done;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", 32'(quotient), 32'(0));
        check("rst_r", 32'(remainder), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_flags", 32'({dbz, ovf}), 32'(0));
        @(negedge clk); rst_n = 1'b1;

        run_op("m40d4", 10'h3D8, 5'h04, 11);   check_res("m40d4", 10'h3F6, 5'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'(0));
        run_op("110dm11", 10'h06E, 5'h15, 11); check_res("110dm11", 10'h3F6, 5'h00, 1'b0, 1'b0);
        run_op("m33dm3", 10'h3DF, 5'h1D, 11);  check_res("m33dm3", 10'h00B, 5'h00, 1'b0, 1'b0);
        run_op("m7d2", 10'h3F9, 5'h02, 11);    check_res("m7d2", 10'h3FD, 5'h1F, 1'b0, 1'b0);
        run_op("7dm2", 10'h007, 5'h1E, 11);    check_res("7dm2", 10'h3FD, 5'h01, 1'b0, 1'b0);
        run_op("5d7", 10'h005, 5'h07, 11);     check_res("5d7", 10'h000, 5'h05, 1'b0, 1'b0);
        run_op("dbz", 10'h07B, 5'h00, 1);      check_res("dbz", 10'h000, 5'h00, 1'b1, 1'b0);
        run_op("9d3", 10'h009, 5'h03, 11);     check_res("9d3", 10'h003, 5'h00, 1'b0, 1'b0);
        run_op("ovf", 10'h200, 5'h1F, 11);     check_res("ovf", 10'h200, 5'h00, 1'b0, 1'b1);
        run_op("m512d1", 10'h200, 5'h01, 11);  check_res("m512d1", 10'h200, 5'h00, 1'b0, 1'b0);

        // Start pulsed mid-division is ignored: 100 / 7 = 14 r 2.
        @(negedge clk); start = 1'b1; dividend = 10'h064; divisor = 5'h07;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 10'h3FF; divisor = 5'h01;
        @(negedge clk); start = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 20 && seen_done == 0; i++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1;
        end
        check("ign_done", 32'(seen_done), 32'(1));
        check_res("ign", 10'h00E, 5'h02, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("ign_no_relaunch", 32'(busy), 32'(0));

        // Reset mid-division discards the operation.
        @(negedge clk); start = 1'b1; dividend = 10'h3D8; divisor = 5'h04;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_q", 32'(quotient), 32'(0));
        check("mid_rst_r", 32'(remainder), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        @(negedge clk); rst_n = 1'b1;
        seen_done = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (done) seen_done = 1;
        end
        check("mid_rst_no_done", 32'(seen_done), 32'(0));

        // Fresh operation after reset: 77 / -6 = -12 r 5.
        run_op("77dm6", 10'h04D, 5'h1A, 11);   check_res("77dm6", 10'h3F4, 5'h05, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
